// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM states, ls_size encodings, requester ids and byte-count helper
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
    typedef enum logic {REQ_IF, REQ_LS} req_id_t;
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    function automatic logic [2:0] byte_count(input req_id_t id, input logic [1:0] size);
        return (id == REQ_IF) ? 3'd4 : (size == SZ_B) ? 3'd1 : (size == SZ_H) ? 3'd2 : 3'd4;
    endfunction
endpackage

// File: rtl/mem_arb_grant.sv
// mem_arb_grant: picks fetch or load/store when the arbiter is idle
// Ports: clk/rst (sync active-high), if_req/ls_req requests, take = a grant is being accepted
// this cycle, gnt = chosen requester. Macro MEM_ARB_RR_EN selects round-robin with a
// last-served flag (reset to fetch); otherwise load/store has fixed priority.
module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    if_req,
    input  logic    ls_req,
    input  logic    take,
    output req_id_t gnt
);
`ifdef MEM_ARB_RR_EN
    req_id_t last_q, last_d;
    always_comb begin
        gnt = (if_req && ls_req) ? ((last_q == REQ_LS) ? REQ_IF : REQ_LS) : (ls_req ? REQ_LS : REQ_IF);
        last_d = take ? gnt : last_q;
    end
    always_ff @(posedge clk) begin
        if (rst) last_q <= REQ_IF;
        else last_q <= last_d;
    end
`else
    logic unused_rr;
    assign unused_rr = ^{clk, rst, take, if_req};
    assign gnt = ls_req ? REQ_LS : REQ_IF;
`endif
endmodule

// File: rtl/mem_byte_arbiter.sv
// mem_byte_arbiter: serialises fetch and load/store accesses onto a byte-wide memory
// Ports: clk, rst (sync active-high); fetch side if_req/if_addr -> if_rdata/if_done (4-byte reads);
// load/store side ls_req/ls_we/ls_size/ls_addr/ls_wdata -> ls_rdata/ls_done;
// memory side mem_addr/mem_we/mem_wdata out, mem_rdata in (combinational read).
// Macro MEM_ARB_RR_EN switches arbitration to round-robin (see mem_arb_grant).
module mem_byte_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_done,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic [31:0]       ls_rdata,
    output logic              ls_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);
    state_t            state_q, state_d;
    req_id_t           gnt, owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d, mem_addr_q, mem_addr_d;
    logic              we_q, we_d, mem_we_q, mem_we_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       res_q, res_d, if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d, merged;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              if_done_q, if_done_d, ls_done_q, ls_done_d, last, take;

    assign take = (state_q == IDLE) && (if_req || ls_req);

    mem_arb_grant u_grant (
        .clk    (clk),
        .rst    (rst),
        .if_req (if_req),
        .ls_req (ls_req),
        .take   (take),
        .gnt    (gnt)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        res_d       = res_q;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        if_done_d   = 1'b0;
        ls_done_d   = 1'b0;
        mem_addr_d  = '0;
        mem_we_d    = 1'b0;
        mem_wdata_d = 8'h00;
        merged      = res_q | (32'(mem_rdata) << {idx_q, 3'b000});
        last        = {1'b0, idx_q} == cnt_q - 3'd1;
        if (take) begin
            state_d     = XFER;
            owner_d     = gnt;
            addr_d      = (gnt == REQ_LS) ? ls_addr : if_addr;
            we_d        = (gnt == REQ_LS) && ls_we;
            cnt_d       = byte_count(gnt, ls_size);
            idx_d       = 2'd0;
            res_d       = 32'h0;
            mem_addr_d  = addr_d;
            mem_we_d    = we_d;
            mem_wdata_d = we_d ? ls_wdata[7:0] : 8'h00;
        end else if (state_q == XFER) begin
            res_d = we_q ? res_q : merged;
            if (last) begin
                state_d    = DONE;
                if_done_d  = owner_q == REQ_IF;
                ls_done_d  = owner_q == REQ_LS;
                if_rdata_d = (owner_q == REQ_IF) ? merged : if_rdata_q;
                ls_rdata_d = (owner_q == REQ_LS && !we_q) ? merged : ls_rdata_q;
            end else begin
                idx_d       = idx_q + 2'd1;
                mem_addr_d  = addr_q + ADDR_W'(idx_d);
                mem_we_d    = we_q;
                mem_wdata_d = we_q ? ls_wdata[{idx_d, 3'b000} +: 8] : 8'h00;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= REQ_IF;
            addr_q      <= '0;
            we_q        <= 1'b0;
            cnt_q       <= 3'd0;
            idx_q       <= 2'd0;
            res_q       <= 32'h0;
            if_rdata_q  <= 32'h0;
            ls_rdata_q  <= 32'h0;
            if_done_q   <= 1'b0;
            ls_done_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            res_q       <= res_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
            if_done_q   <= if_done_d;
            ls_done_q   <= ls_done_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // A reset landing mid-store must stop the byte being written in that same cycle.
    assign mem_we    = mem_we_q && !rst;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;
    assign if_done   = if_done_q;
    assign ls_done   = ls_done_q;
endmodule
